// File: rtl/usb_reg_sequencer.sv
// Indirect ISP1362 register-access sequencer: round-robin arbitration of two requesters,
// then the command / recovery-gap / data strobe pattern on the controller's Avalon slave port.
module usb_reg_sequencer #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_write,
  input  logic [1:0]  req_dc,
  input  logic [13:0] req_cmd,
  input  logic [1:0]  req_wide,
  input  logic [63:0] req_wdata,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        read,
  output logic        write,
  output logic [15:0] writedata,
  input  logic [15:0] readdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_GAP_A   = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_GAP_B   = 3'd4,
    ST_DATA_HI = 3'd5,
    ST_GAP_C   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 32'd1);

  state_t      state_r, next_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        last_r, last_s;
  logic        grant_r, grant_s;
  logic        op_wr_r, op_wr_s;
  logic        dc_r, dc_s;
  logic        wide_r, wide_s;
  logic [6:0]  cmd_r, cmd_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rbuf_r, rbuf_s;

  logic [1:0]  address_r, address_s;
  logic        chipselect_r, chipselect_s;
  logic        read_r, read_s;
  logic        write_r, write_s;
  logic [15:0] writedata_r, writedata_s;
  logic [1:0]  done_r, done_s;
  logic [31:0] rdata_r, rdata_s;
  logic        busy_r, busy_s;

  assign address    = address_r;
  assign chipselect = chipselect_r;
  assign read       = read_r;
  assign write      = write_r;
  assign writedata  = writedata_r;
  assign done       = done_r;
  assign rdata      = rdata_r;
  assign busy       = busy_r;

  // Next state, latched fields, and the output values for the cycle being entered.
  always_comb begin
    next_s       = state_r;
    cnt_s        = cnt_r;
    last_s       = last_r;
    grant_s      = grant_r;
    op_wr_s      = op_wr_r;
    dc_s         = dc_r;
    wide_s       = wide_r;
    cmd_s        = cmd_r;
    wdata_s      = wdata_r;
    rbuf_s       = rbuf_r;
    address_s    = 2'b00;
    chipselect_s = 1'b0;
    read_s       = 1'b0;
    write_s      = 1'b0;
    writedata_s  = 16'h0000;
    done_s       = 2'b00;
    rdata_s      = rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester not served last wins.
          grant_s = (req == 2'b11) ? ~last_r : req[1];
          op_wr_s = req_write[grant_s];
          dc_s    = req_dc[grant_s];
          wide_s  = req_wide[grant_s];
          cmd_s   = grant_s ? req_cmd[13:7] : req_cmd[6:0];
          wdata_s = grant_s ? req_wdata[63:32] : req_wdata[31:0];
          next_s  = ST_CMD;
        end else begin
          next_s  = ST_IDLE;
        end
      end
      ST_CMD: begin
        cnt_s  = GAP_LOAD;
        next_s = ST_GAP_A;
      end
      ST_GAP_A: begin
        if (cnt_r == 4'd0) next_s = ST_DATA_LO;
        else cnt_s = cnt_r - 4'd1;
      end
      ST_DATA_LO: begin
        if (!op_wr_r) rbuf_s = {16'h0000, readdata};
        else rbuf_s = rbuf_r;
        cnt_s  = GAP_LOAD;
        next_s = ST_GAP_B;
      end
      ST_GAP_B: begin
        if (cnt_r == 4'd0) next_s = wide_r ? ST_DATA_HI : ST_DONE;
        else cnt_s = cnt_r - 4'd1;
      end
      ST_DATA_HI: begin
        if (!op_wr_r) rbuf_s = {readdata, rbuf_r[15:0]};
        else rbuf_s = rbuf_r;
        cnt_s  = GAP_LOAD;
        next_s = ST_GAP_C;
      end
      ST_GAP_C: begin
        if (cnt_r == 4'd0) next_s = ST_DONE;
        else cnt_s = cnt_r - 4'd1;
      end
      ST_DONE: begin
        last_s = grant_r;
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they can be registered.
    case (next_s)
      ST_CMD: begin
        chipselect_s = 1'b1;
        write_s      = 1'b1;
        address_s    = {dc_s, 1'b1};
        writedata_s  = {8'h00, op_wr_s, cmd_s};
      end
      ST_DATA_LO, ST_DATA_HI: begin
        chipselect_s = 1'b1;
        address_s    = {dc_s, 1'b0};
        if (op_wr_s) begin
          write_s     = 1'b1;
          writedata_s = (next_s == ST_DATA_HI) ? wdata_s[31:16] : wdata_s[15:0];
        end else begin
          read_s      = 1'b1;
        end
      end
      ST_DONE: begin
        done_s  = grant_s ? 2'b10 : 2'b01;
        rdata_s = rbuf_s;
      end
      default: begin
        chipselect_s = 1'b0;
      end
    endcase

    busy_s = (next_s != ST_IDLE);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      last_r       <= 1'b1;
      grant_r      <= 1'b0;
      op_wr_r      <= 1'b0;
      dc_r         <= 1'b0;
      wide_r       <= 1'b0;
      cmd_r        <= 7'd0;
      wdata_r      <= 32'd0;
      rbuf_r       <= 32'd0;
      address_r    <= 2'b00;
      chipselect_r <= 1'b0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= 16'h0000;
      done_r       <= 2'b00;
      rdata_r      <= 32'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_s;
      cnt_r        <= cnt_s;
      last_r       <= last_s;
      grant_r      <= grant_s;
      op_wr_r      <= op_wr_s;
      dc_r         <= dc_s;
      wide_r       <= wide_s;
      cmd_r        <= cmd_s;
      wdata_r      <= wdata_s;
      rbuf_r       <= rbuf_s;
      address_r    <= address_s;
      chipselect_r <= chipselect_s;
      read_r       <= read_s;
      write_r      <= write_s;
      writedata_r  <= writedata_s;
      done_r       <= done_s;
      rdata_r      <= rdata_s;
      busy_r       <= busy_s;
    end
  end

endmodule

// File: tb/tb_usb_reg_sequencer.sv
// Bench for usb_reg_sequencer: transaction-level reference model (G=4) plus a G=1
// instance driven randomly for strobe spacing and completion accounting.
module tb_usb_reg_sequencer;
  localparam int G  = 4;
  localparam int G1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  req, req_write, req_dc, req_wide, done, address;
  logic [13:0] req_cmd;
  logic [63:0] req_wdata;
  logic [31:0] rdata;
  logic        busy, chipselect, read, write;
  logic [15:0] writedata, readdata;

  logic [1:0]  req1, req_write1, req_dc1, req_wide1, done1, address1;
  logic [13:0] req_cmd1;
  logic [63:0] req_wdata1;
  logic [31:0] rdata1;
  logic        busy1, chipselect1, read1, write1;
  logic [15:0] writedata1, readdata1;

  usb_reg_sequencer #(.GAP_CYCLES(G)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_dc(req_dc),
    .req_cmd(req_cmd), .req_wide(req_wide), .req_wdata(req_wdata), .done(done),
    .rdata(rdata), .busy(busy), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata));

  usb_reg_sequencer #(.GAP_CYCLES(G1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_write(req_write1), .req_dc(req_dc1),
    .req_cmd(req_cmd1), .req_wide(req_wide1), .req_wdata(req_wdata1), .done(done1),
    .rdata(rdata1), .busy(busy1), .address(address1), .chipselect(chipselect1),
    .read(read1), .write(write1), .writedata(writedata1), .readdata(readdata1));

  int    checks = 0;
  int    failures = 0;
  int    c = 0;
  string tname;
  bit    auto_repost = 1'b0;
  logic [15:0] rd_lo [2];
  logic [15:0] rd_hi [2];
  int    grant_log [$];

  // Transaction-level model: one active access, start cycle, latched fields.
  bit          m_act;
  int          m_s;
  logic        m_g, m_last, m_wr, m_dc, m_wide;
  logic [6:0]  m_cmd;
  logic [31:0] m_wd, m_rdata;
  logic [15:0] m_rlo, m_rhi;

  function automatic int dur_of(input logic wide);
    return wide ? 3 * G + 4 : 2 * G + 3;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_last = 1'b1; m_rdata = 32'd0;
    grant_log.delete();
  endtask

  // One clock: compare every output with the model's schedule, then play the slave.
  task automatic tick();
    logic [55:0] exp_v, obs_v;
    logic        e_cs, e_rd, e_wr, e_busy;
    logic [1:0]  e_addr, e_done;
    logic [15:0] e_wd, rd_val;
    int          off;
    @(posedge clk); #1; c++;
    e_cs = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
    e_addr = 2'b00; e_done = 2'b00; e_wd = 16'h0000; rd_val = 16'($urandom);
    if (m_act && c > m_s + dur_of(m_wide)) m_act = 1'b0;
    if (m_act) begin
      off = c - m_s;
      e_busy = 1'b1;
      if (off == 1) begin
        e_cs = 1'b1; e_wr = 1'b1; e_addr = {m_dc, 1'b1}; e_wd = {8'h00, m_wr, m_cmd};
      end else if (off == G + 2 || (m_wide && off == 2 * G + 3)) begin
        e_cs = 1'b1; e_addr = {m_dc, 1'b0};
        if (m_wr) begin
          e_wr = 1'b1; e_wd = (off == G + 2) ? m_wd[15:0] : m_wd[31:16];
        end else begin
          e_rd = 1'b1; rd_val = (off == G + 2) ? m_rlo : m_rhi;
        end
      end
      if (off == dur_of(m_wide)) begin
        e_done = m_g ? 2'b10 : 2'b01;
        m_last = m_g;
        if (!m_wr) m_rdata = m_wide ? {m_rhi, m_rlo} : {16'h0000, m_rlo};
        if (!auto_repost) req[m_g] = 1'b0;
      end
    end
    if (done == 2'b01) grant_log.push_back(0);
    if (done == 2'b10) grant_log.push_back(1);
    exp_v = {e_busy, e_done, e_cs, e_rd, e_wr, e_addr, e_wd, m_rdata};
    obs_v = {busy, done, chipselect, read, write, chipselect ? address : 2'b00,
             write ? writedata : 16'h0000, rdata};
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL %s cycle %0d outputs got=%h expected=%h", tname, c, obs_v, exp_v);
    end
    readdata = rd_val;
  endtask

  // Grant decision for the current cycle from the requests now on the inputs.
  task automatic arb();
    if (!m_act && req != 2'b00) begin
      if (req == 2'b11) m_g = ~m_last;
      else m_g = req[1];
      m_act = 1'b1; m_s = c;
      m_wr = req_write[m_g]; m_dc = req_dc[m_g]; m_wide = req_wide[m_g];
      m_cmd = m_g ? req_cmd[13:7] : req_cmd[6:0];
      m_wd = m_g ? req_wdata[63:32] : req_wdata[31:0];
      m_rlo = rd_lo[m_g]; m_rhi = rd_hi[m_g];
    end
  endtask

  task automatic cycle();
    tick(); arb();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic post(input int n, input logic wr, input logic dc, input logic [6:0] cmd,
                      input logic wide, input logic [31:0] wd, input logic [15:0] lo,
                      input logic [15:0] hi);
    req_write[n] = wr; req_dc[n] = dc; req_wide[n] = wide;
    req_cmd[7*n +: 7] = cmd; req_wdata[32*n +: 32] = wd;
    rd_lo[n] = lo; rd_hi[n] = hi;
    req[n] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; req1 = 2'b00;
    repeat (2) @(posedge clk);
    #1; c = c + 2;
    checks++;
    if ({done, rdata, busy, address, chipselect, read, write, writedata} !== 56'd0) begin
      failures++;
      $display("FAIL %s reset outputs got=%h required=0", tname,
               {done, rdata, busy, address, chipselect, read, write, writedata});
    end
    checks++;
    if ({done1, rdata1, busy1, address1, chipselect1, read1, write1, writedata1} !== 56'd0) begin
      failures++;
      $display("FAIL %s reset outputs g1 got=%h required=0", tname,
               {done1, rdata1, busy1, address1, chipselect1, read1, write1, writedata1});
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    tname = "reset";
    req_write = 2'b00; req_dc = 2'b00; req_wide = 2'b00; req_cmd = 14'd0; req_wdata = 64'd0;
    req_write1 = 2'b00; req_dc1 = 2'b00; req_wide1 = 2'b00; req_cmd1 = 14'd0;
    req_wdata1 = 64'd0; readdata = 16'h0000; readdata1 = 16'h0000;
    do_reset();
    run(3);
  endtask

  task automatic test_narrow_write();
    int s0;
    tname = "narrow_write";
    post(0, 1'b1, 1'b0, 7'h2A, 1'b0, 32'hCAFE_1234, 16'h0000, 16'h0000);
    arb(); s0 = c;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (c - s0 == 1) begin
        checks++;
        if ({address, writedata, write} !== {2'd1, 16'h00AA, 1'b1}) begin
          failures++;
          $display("FAIL narrow_write cmd got=%h required=%h", {address, writedata, write},
                   {2'd1, 16'h00AA, 1'b1});
        end
      end
      if (c - s0 == 6) begin
        checks++;
        if ({address, writedata, write} !== {2'd0, 16'h1234, 1'b1}) begin
          failures++;
          $display("FAIL narrow_write data got=%h required=%h", {address, writedata, write},
                   {2'd0, 16'h1234, 1'b1});
        end
      end
      if (c - s0 == 11) begin
        checks++;
        if (done !== 2'b01) begin
          failures++;
          $display("FAIL narrow_write done got=%b required=01", done);
        end
      end
    end
  endtask

  task automatic test_wide_read();
    int s0;
    tname = "wide_read";
    post(1, 1'b0, 1'b1, 7'h11, 1'b1, $urandom, 16'hBEEF, 16'hDEAD);
    arb(); s0 = c;
    for (int k = 0; k < 18; k++) begin
      cycle();
      if (c - s0 == 1) begin
        checks++;
        if ({address, writedata} !== {2'd3, 16'h0011}) begin
          failures++;
          $display("FAIL wide_read cmd got=%h required=%h", {address, writedata}, {2'd3, 16'h0011});
        end
      end
      if (c - s0 == 6 || c - s0 == 11) begin
        checks++;
        if ({address, read} !== {2'd2, 1'b1}) begin
          failures++;
          $display("FAIL wide_read data strobe got=%h required=%h", {address, read}, {2'd2, 1'b1});
        end
      end
      if (c - s0 == 16) begin
        checks++;
        if ({done, rdata} !== {2'b10, 32'hDEADBEEF}) begin
          failures++;
          $display("FAIL wide_read done got=%h required=%h", {done, rdata}, {2'b10, 32'hDEADBEEF});
        end
      end
    end
  endtask

  task automatic test_narrow_after_wide();
    bit seen = 1'b0;
    tname = "narrow_after_wide";
    post(1, 1'b0, 1'b0, 7'h05, 1'b1, 32'd0, 16'h1111, 16'h2222);
    arb();
    run(3);
    post(0, 1'b0, 1'b1, 7'h33, 1'b0, 32'd0, 16'h00FF, 16'h0000);
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (done[0] === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (rdata !== 32'h000000FF) begin
          failures++;
          $display("FAIL narrow_after_wide rdata got=%h required=000000ff", rdata);
        end
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL narrow_after_wide timeout got=no done required=done[0]");
    end
    run(3);
  endtask

  task automatic test_arbitration();
    logic [3:0] got;
    tname = "arbitration";
    do_reset();
    auto_repost = 1'b1;
    post(0, 1'b1, 1'b0, 7'h01, 1'b0, $urandom, 16'h0000, 16'h0000);
    post(1, 1'b0, 1'b1, 7'h02, 1'b0, 32'd0, 16'($urandom), 16'h0000);
    arb();
    for (int k = 0; k < 120 && grant_log.size() < 4; k++) cycle();
    checks++;
    if (grant_log.size() < 4) begin
      failures++;
      $display("FAIL arbitration grants got=%0d required=4", grant_log.size());
    end else begin
      got = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
      if (got !== 4'b0101) begin
        failures++;
        $display("FAIL arbitration order got=%b required=0101", got);
      end
    end
    auto_repost = 1'b0;
    req = 2'b00;
    run(20);
  endtask

  task automatic test_withdraw_reset();
    int s0;
    bit seen = 1'b0;
    tname = "withdraw";
    post(0, $urandom_range(0, 1) == 1, 1'b0, 7'h44, 1'b1, $urandom, 16'hA5A5, 16'h5A5A);
    arb(); s0 = c;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (c - s0 == 3) req[0] = 1'b0;
      if (done[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL withdraw done got=none required=done[0]");
    end
    tname = "midreset";
    post(1, 1'b0, 1'b1, 7'h12, 1'b1, 32'd0, 16'h1357, 16'h2468);
    arb(); s0 = c;
    while (c - s0 < 6) cycle();
    checks++;
    if (chipselect !== 1'b1) begin
      failures++;
      $display("FAIL midreset pre-strobe got=%b required=1", chipselect);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({chipselect, read, busy} !== 3'b000) begin
      failures++;
      $display("FAIL midreset async got=%b required=000", {chipselect, read, busy});
    end
    req = 2'b00;
    @(posedge clk); #1; c++;
    reset = 1'b0;
    model_reset();
    run(3 * G + 10);
  endtask

  task automatic test_random();
    tname = "random";
    for (int k = 0; k < 400; k++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!req[n] && $urandom_range(0, 3) == 0)
          post(n, 1'($urandom), 1'($urandom), 7'($urandom), 1'($urandom), $urandom,
               16'($urandom), 16'($urandom));
        else if (req[n] && $urandom_range(0, 7) == 0)
          post(n, 1'($urandom), 1'($urandom), 7'($urandom), 1'($urandom), $urandom,
               16'($urandom), 16'($urandom));
      end
      arb();
    end
    run(50);
  endtask

  task automatic test_strobe_g1();
    int last_cs = -100;
    int posts = 0;
    int dones = 0;
    tname = "strobe_g1";
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1; c++;
      checks++;
      if ((read1 & write1) !== 1'b0) begin
        failures++;
        $display("FAIL strobe_g1 rw_overlap cycle %0d got=1 required=0", c);
      end
      if (chipselect1 === 1'b1) begin
        checks++;
        if (c - last_cs < G1 + 1) begin
          failures++;
          $display("FAIL strobe_g1 spacing got=%0d required>=%0d", c - last_cs, G1 + 1);
        end
        last_cs = c;
      end
      checks++;
      if ((done1 & ~req1) !== 2'b00) begin
        failures++;
        $display("FAIL strobe_g1 stray_done got=%b req=%b", done1, req1);
      end
      for (int n = 0; n < 2; n++) begin
        if (done1[n] === 1'b1) begin
          req1[n] = 1'b0; dones++;
        end else if (!req1[n] && k < 440 && $urandom_range(0, 2) == 0) begin
          req_write1[n] = 1'($urandom); req_dc1[n] = 1'($urandom);
          req_wide1[n] = 1'($urandom); req_cmd1[7*n +: 7] = 7'($urandom);
          req_wdata1[32*n +: 32] = $urandom;
          req1[n] = 1'b1; posts++;
        end
      end
      readdata1 = 16'($urandom);
    end
    checks++;
    if (dones !== posts || req1 !== 2'b00) begin
      failures++;
      $display("FAIL strobe_g1 completions got=%0d required=%0d pending=%b", dones, posts, req1);
    end
  endtask

  initial begin
    test_reset();
    test_narrow_write();
    test_wide_read();
    test_narrow_after_wide();
    test_arbitration();
    test_withdraw_reset();
    test_random();
    test_strobe_g1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_reg_sequencer.md
# usb_reg_sequencer

Sequences indirect register accesses to the ISP1362 USB OTG controller through its 4-word Avalon-MM slave port (address, chipselect, read, write, writedata, readdata). Two hardware requesters share the port through round-robin arbitration. For each request the block issues the command-port write, the required bus-recovery gaps, and one or two 16-bit data-port accesses, then returns a completion pulse with read data. It sits between the USB host-driver logic and the USB controller wrapper.

## Interface

**Parameters**
- `GAP_CYCLES`, default 4: idle clock cycles between consecutive bus strobes (ISP1362 recovery); legal range 1..15.

**Ports**
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 2: per-requester request level; bit n belongs to requester n.
- `req_write` in 2: 1 = register write, 0 = register read.
- `req_dc` in 2: 1 = device-controller port (address bit 1 set); 0 = host-controller port.
- `req_cmd` in 14: 7-bit register index per requester; requester n uses bits [7n+6:7n].
- `req_wide` in 2: 1 = 32-bit register, two data accesses; 0 = 16-bit register.
- `req_wdata` in 64: 32-bit write data per requester; requester n uses bits [32n+31:32n].
- `done` out 2: one-cycle completion pulse to the served requester.
- `rdata` out 32: read result; valid when any `done` bit is high; holds until the next completion.
- `busy` out 1: high from grant until the end of the DONE state.
- `address` out 2: to the USB controller slave.
- `chipselect` out 1: to the USB controller slave.
- `read` out 1: to the USB controller slave.
- `write` out 1: to the USB controller slave.
- `writedata` out 16: to the USB controller slave.
- `readdata` in 16: from the USB controller slave; zero-wait-state, sampled on the edge that ends a read strobe cycle.

## Operation

- FSM states, in order: IDLE, CMD, GAP_A, DATA_LO, GAP_B, DATA_HI, GAP_C, DONE.
- **IDLE:** if any `req` is high, grant one requester and latch its `req_*` fields into internal registers. Go to CMD.
- **Arbitration:** round-robin with a last-served pointer.
  - A single active request is always granted.
  - On a tie, the requester not served last wins.
  - After reset the pointer favours requester 0.
- **CMD:** one strobe cycle.
  - `chipselect=1`, `write=1`, `address={dc,1}`, `writedata={8'h00, wr, cmd[6:0]}`.
  - Bit 7 is set for register writes (ISP1362 write-command convention).
- **GAP_A, GAP_B, GAP_C:** each lasts exactly `GAP_CYCLES` cycles with all strobes low. A 4-bit counter counts them.
- **DATA_LO:** one strobe cycle with `chipselect=1` and `address={dc,0}`.
  - Write: `write=1`, `writedata=wdata[15:0]`.
  - Read: `read=1`; capture `readdata` into `rdata[15:0]` and clear `rdata[31:16]`.
- **After GAP_B:** go to DATA_HI if `wide`, otherwise go to DONE. A narrow access therefore skips DATA_HI and GAP_C.
- **DATA_HI:** same as DATA_LO but uses `wdata[31:16]` and captures into `rdata[31:16]`.
- **DONE:** pulse `done[grant]` for one cycle, update the last-served pointer, go to IDLE.
- **Request level rule:** each requester clears its `req` on the edge where it samples its `done`=1. The block does not mask the next IDLE cycle.
- **Mid-transaction changes:** fields are latched at grant. Changes to `req_*`, including dropping `req`, do not affect a transaction in flight; it still completes and still pulses `done`.
- Only one strobe is active in any cycle; `read` and `write` are never high together.

## Timing

- **Reset values:** state IDLE, pointer favours requester 0, and every output 0 (`address`, `chipselect`, `read`, `write`, `writedata`, `done`, `rdata`, `busy`).
- **Reset mid-transaction:** strobes drop immediately (asynchronous), no `done` is issued, and the transaction is lost.
- **Cycle numbering:** request seen in IDLE at cycle 0, G = `GAP_CYCLES`.

| Event | Narrow access | Wide access |
|---|---|---|
| CMD strobe | cycle 1 | cycle 1 |
| DATA_LO strobe | cycle G+2 | cycle G+2 |
| DATA_HI strobe | none | cycle 2G+3 |
| `done` | cycle 2G+3 | cycle 3G+4 |

- With G=4: narrow `done` at cycle 11, wide `done` at cycle 16.
- The next grant happens at the earliest in the IDLE cycle right after DONE. Back-to-back service costs one extra IDLE cycle per transaction.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan

1. **Narrow write.** Requester 0 writes host-controller register 0x2A, data 0x1234, G=4.
   - Cycle 1: `address=1`, `writedata=0x00AA`, `write=1`.
   - Cycle 6: `address=0`, `writedata=0x1234`.
   - Cycle 11: `done=2'b01`.
2. **Wide read.** Requester 1 reads device-controller register 0x11, wide. Slave returns 0xBEEF, then 0xDEAD.
   - Cycle 1: `address=3`, `writedata=0x0011`.
   - Data strobes at `address=2`.
   - Cycle 16: `done=2'b10`, `rdata=0xDEADBEEF`.
3. **Narrow read after wide.** A narrow read returning 0x00FF immediately follows a wide read.
   - `rdata=0x000000FF`; the upper half is cleared.
4. **Arbitration tie.** Both requesters are held high continuously.
   - Grants alternate 0, 1, 0, 1.
   - After reset with both requests high, requester 0 goes first.
5. **Withdrawal and reset.**
   - Requester 0 drops `req` at cycle 3: the transaction completes and `done[0]` still pulses.
   - Separately, assert `reset` at cycle 6: `chipselect` goes low asynchronously, and no `done` pulse follows.
6. **Strobe exclusivity.** Random stimulus with G=1.
   - Never more than one strobe cycle in any window of G+1 cycles.
   - `read & write` is never high.
